// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared encodings, FSM state type and helpers for conv_win_ctrl
package conv_pkg;

    localparam logic [1:0] STRIDE_1    = 2'd0;
    localparam logic [1:0] STRIDE_2    = 2'd1;
    localparam logic [1:0] STRIDE_4    = 2'd2;
    localparam logic [1:0] STRIDE_RSVD = 2'd3;

    localparam logic [1:0] DIL_1    = 2'd0;
    localparam logic [1:0] DIL_2    = 2'd1;
    localparam logic [1:0] DIL_4    = 2'd2;
    localparam logic [1:0] DIL_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    function automatic logic [2:0] sel_to_factor(input logic [1:0] sel);
        case (sel)
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic int clogb2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    localparam int MAX_FACTOR = 4;
    localparam int PHASE_W    = clogb2(MAX_FACTOR);

endpackage

// File: rtl/conv_win_pos_cnt.sv
// rtl/conv_win_pos_cnt.sv - col/row/channel position counters with stride phase tracking
module conv_win_pos_cnt
    import conv_pkg::*;
#(
    parameter int TILE_W    = 32,
    parameter int TILE_H    = 32,
    parameter int NUM_CH    = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 step_i,
    input  logic [2:0]           stride_i,
    output logic [CNT_WIDTH-1:0] col_o,
    output logic [CNT_WIDTH-1:0] row_o,
    output logic [CNT_WIDTH-1:0] ch_o,
    output logic [PHASE_W-1:0]   col_phase_o,
    output logic [PHASE_W-1:0]   row_phase_o,
    output logic                 last_o
);

    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(TILE_W - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(TILE_H - 1);
    localparam logic [CNT_WIDTH-1:0] CH_LAST  = CNT_WIDTH'(NUM_CH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;
    localparam logic [PHASE_W-1:0]   PH_ONE   = 1;

    logic [CNT_WIDTH-1:0] col_q, col_d, row_q, row_d, ch_q, ch_d;
    logic [PHASE_W-1:0]   col_phase_q, col_phase_d, row_phase_q, row_phase_d;
    logic [PHASE_W-1:0]   stride_m1;
    logic                 col_wrap, row_wrap, ch_last;

    assign stride_m1 = PHASE_W'(stride_i - 3'd1);
    assign col_wrap  = (col_q == COL_LAST);
    assign row_wrap  = (row_q == ROW_LAST);
    assign ch_last   = (ch_q == CH_LAST);

    // Phases count modulo the stride with a compare-and-reset, so no divider is needed.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        ch_d        = ch_q;
        col_phase_d = col_phase_q;
        row_phase_d = row_phase_q;
        if (clr_i) begin
            col_d       = '0;
            row_d       = '0;
            ch_d        = '0;
            col_phase_d = '0;
            row_phase_d = '0;
        end else if (step_i) begin
            if (col_wrap) begin
                col_d       = '0;
                col_phase_d = '0;
                if (row_wrap) begin
                    row_d       = '0;
                    row_phase_d = '0;
                    ch_d        = ch_last ? '0 : ch_q + CNT_ONE;
                end else begin
                    row_d       = row_q + CNT_ONE;
                    row_phase_d = (row_phase_q == stride_m1) ? '0 : row_phase_q + PH_ONE;
                end
            end else begin
                col_d       = col_q + CNT_ONE;
                col_phase_d = (col_phase_q == stride_m1) ? '0 : col_phase_q + PH_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            col_phase_q <= '0;
            row_phase_q <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            col_phase_q <= col_phase_d;
            row_phase_q <= row_phase_d;
        end
    end

    assign col_o       = col_q;
    assign row_o       = row_q;
    assign ch_o        = ch_q;
    assign col_phase_o = col_phase_q;
    assign row_phase_o = row_phase_q;
    assign last_o      = col_wrap && row_wrap && ch_last;

endmodule

// File: rtl/conv_win_ctrl.sv
// rtl/conv_win_ctrl.sv - tile window/stride output filter; CONV_WIN_CTRL_PROTO_CHECK_EN enables err_o
module conv_win_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int TILE_W      = 32,
    parameter int TILE_H      = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int NUM_CH      = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [1:0]            stride_sel_i,
    input  logic [1:0]            dil_sel_i,
    input  logic                  data_valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  busy_o,
    output logic                  op_valid_o,
    output logic [DATA_WIDTH-1:0] op_data_o,
    output logic [CNT_WIDTH-1:0]  ch_idx_o,
    output logic                  done_o,
    output logic                  err_o
);

    conv_state_e           state_q, state_d;
    logic [2:0]            stride_q, stride_d, dil_q, dil_d;
    logic                  busy_q, busy_d, op_valid_q, op_valid_d, done_q, done_d;
    logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
    logic [CNT_WIDTH-1:0]  ch_idx_q, ch_idx_d;

    logic [CNT_WIDTH-1:0]  col, row, ch;
    logic [PHASE_W-1:0]    col_phase, row_phase;
    logic                  last_beat, accept_start, beat, keep;
    logic [31:0]           span;

    assign accept_start = (state_q == ST_IDLE) && start_i;
    assign beat         = (state_q == ST_RUN) && data_valid_i;

    conv_win_pos_cnt #(
        .TILE_W    (TILE_W),
        .TILE_H    (TILE_H),
        .NUM_CH    (NUM_CH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pos_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (accept_start),
        .step_i      (beat),
        .stride_i    (stride_q),
        .col_o       (col),
        .row_o       (row),
        .ch_o        (ch),
        .col_phase_o (col_phase),
        .row_phase_o (row_phase),
        .last_o      (last_beat)
    );

    // Compare as pos + SPAN < TILE so an oversized span simply keeps nothing.
    always_comb begin
        span = 32'(KERNEL_SIZE - 1) * 32'(dil_q);
        keep = ((32'(col) + span) < 32'(TILE_W)) && ((32'(row) + span) < 32'(TILE_H)) &&
               (col_phase == '0) && (row_phase == '0);
    end

    always_comb begin
        state_d  = state_q;
        stride_d = stride_q;
        dil_d    = dil_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    stride_d = sel_to_factor(stride_sel_i);
                    dil_d    = sel_to_factor(dil_sel_i);
                end
            end
            ST_RUN:  if (beat && last_beat) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d     = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        op_valid_d = beat && keep;
        op_data_d  = op_valid_d ? data_i : '0;
        ch_idx_d   = ch;
    end

`ifdef CONV_WIN_CTRL_PROTO_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept_start) err_d = (stride_sel_i == STRIDE_RSVD) || (dil_sel_i == DIL_RSVD);
        if (data_valid_i && (state_q != ST_RUN)) err_d = 1'b1;
        if (start_i && (state_q == ST_RUN)) err_d = 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            stride_q   <= 3'd1;
            dil_q      <= 3'd1;
            busy_q     <= 1'b0;
            op_valid_q <= 1'b0;
            op_data_q  <= '0;
            ch_idx_q   <= '0;
            done_q     <= 1'b0;
`ifdef CONV_WIN_CTRL_PROTO_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            stride_q   <= stride_d;
            dil_q      <= dil_d;
            busy_q     <= busy_d;
            op_valid_q <= op_valid_d;
            op_data_q  <= op_data_d;
            ch_idx_q   <= ch_idx_d;
            done_q     <= done_d;
`ifdef CONV_WIN_CTRL_PROTO_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign busy_o     = busy_q;
    assign op_valid_o = op_valid_q;
    assign op_data_o  = op_data_q;
    assign ch_idx_o   = ch_idx_q;
    assign done_o     = done_q;

endmodule
